// File: rtl/servo_ramp_ctrl.sv
// Servo PWM sequencer: command FIFO, per-period slew toward target, hold, retire.
// Optional macro SERVO_RAMP_EN enables STEP_US slewing; otherwise the target is applied in one period.
module servo_ramp_ctrl #(
  parameter logic [15:0] MIN_PW       = 16'd500,
  parameter logic [15:0] MAX_PW       = 16'd2500,
  parameter logic [15:0] CENTER_PW    = 16'd1500,
  parameter logic [15:0] STEP_US      = 16'd10,
  parameter logic [7:0]  HOLD_PERIODS = 8'd2,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] counter_in,
  input  logic        period_start,
  input  logic        cmd_valid,
  input  logic [15:0] cmd_pw,
  output logic        cmd_ready,
  output logic [15:0] pulse_width,
  output logic        pwm_out,
  output logic        busy,
  output logic        done,
  output logic        cmd_err
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RAMP, HOLD} state_t;

  state_t      r_state;
  logic [15:0] r_fifo [FIFO_DEPTH];
  logic [AW:0] r_wr, r_rd;
  logic [15:0] r_target, r_pw;
  logic [7:0]  r_hold;
  logic        r_pwm, r_cmd_err;

  logic        w_empty, w_full, w_push, w_pop;
  logic        w_low, w_high;
  logic [15:0] w_clamped;
  logic        w_up, w_near, w_hold_last;
  logic [15:0] w_dist, w_step_pw;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_empty = (r_wr == r_rd);
  assign w_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_push  = cmd_valid && !w_full;
  assign w_pop   = (r_state == IDLE) && !w_empty;

  assign w_low     = (cmd_pw < MIN_PW);
  assign w_high    = (cmd_pw > MAX_PW);
  assign w_clamped = w_low ? MIN_PW : (w_high ? MAX_PW : cmd_pw);

  // Compare first, then add or subtract, so the 16-bit step never wraps.
  assign w_up      = (r_target > r_pw);
  assign w_dist    = w_up ? (r_target - r_pw) : (r_pw - r_target);
  assign w_step_pw = w_up ? (r_pw + STEP_US) : (r_pw - STEP_US);
`ifdef SERVO_RAMP_EN
  assign w_near    = (w_dist <= STEP_US);
`else
  assign w_near    = 1'b1;
`endif

  assign w_hold_last = (r_hold == HOLD_PERIODS - 8'd1);

  assign cmd_ready   = !w_full;
  assign pulse_width = r_pw;
  assign pwm_out     = r_pwm;
  assign cmd_err     = r_cmd_err;
  assign busy        = (r_state != IDLE) || !w_empty;
  assign done        = (r_state == HOLD) && period_start && w_hold_last;

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr[AW-1:0]] <= w_clamped;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_wr      <= '0;
      r_rd      <= '0;
      r_target  <= CENTER_PW;
      r_pw      <= CENTER_PW;
      r_hold    <= '0;
      r_pwm     <= 1'b0;
      r_cmd_err <= 1'b0;
    end else begin
      r_pwm     <= (counter_in < r_pw);
      r_cmd_err <= w_push && (w_low || w_high);
      if (w_push) r_wr <= r_wr + {{AW{1'b0}}, 1'b1};
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_target <= r_fifo[r_rd[AW-1:0]];
            r_rd     <= r_rd + {{AW{1'b0}}, 1'b1};
            r_state  <= RAMP;
          end
        end
        RAMP: begin
          if (period_start) begin
            if (w_near || w_dist == 16'd0) begin
              r_pw    <= r_target;
              r_hold  <= '0;
              r_state <= HOLD;
            end else begin
              r_pw    <= w_step_pw;
            end
          end
        end
        HOLD: begin
          if (period_start) begin
            if (w_hold_last) begin
              r_hold  <= '0;
              r_state <= IDLE;
            end else begin
              r_hold  <= r_hold + 8'd1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_servo_ramp_ctrl.sv
// Directed bench for servo_ramp_ctrl with a pulse-width/retire scoreboard; follows SERVO_RAMP_EN.
module tb_servo_ramp_ctrl;
  localparam int MIN = 500, MAX = 2500, CEN = 1500, STEP = 10, DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] counter_in = '0;
  logic        period_start = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [15:0] cmd_pw = '0;
  logic        cmd_ready, pwm_out, busy, done, cmd_err;
  logic [15:0] pulse_width;

  always #5 clk = ~clk;

  servo_ramp_ctrl dut (
    .clk(clk), .rst(rst), .counter_in(counter_in), .period_start(period_start),
    .cmd_valid(cmd_valid), .cmd_pw(cmd_pw), .cmd_ready(cmd_ready),
    .pulse_width(pulse_width), .pwm_out(pwm_out), .busy(busy), .done(done),
    .cmd_err(cmd_err)
  );

  int          n_cmp = 0, n_bad = 0;
  int          exp_pw_q[$];
  int          exp_done_q[$];
  int          m_pw = CEN;
  int          m_out = 0;
  bit          mon_off = 1'b1;
  logic [15:0] prev_pw;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Every visible change of pulse_width must be the next expected value.
  always @(negedge clk) begin
    if (mon_off) prev_pw = pulse_width;
    else if (pulse_width !== prev_pw) begin
      if (exp_pw_q.size() == 0) chk("pw_unexpected", {16'd0, pulse_width}, {16'd0, prev_pw});
      else chk("pw_step", {16'd0, pulse_width}, exp_pw_q.pop_front());
      prev_pw = pulse_width;
    end
  end

  function automatic void model_cmd(input int v);
    int t;
    t = (v < MIN) ? MIN : ((v > MAX) ? MAX : v);
`ifdef SERVO_RAMP_EN
    while (m_pw != t) begin
      if (t > m_pw) m_pw = (t - m_pw > STEP) ? m_pw + STEP : t;
      else          m_pw = (m_pw - t > STEP) ? m_pw - STEP : t;
      exp_pw_q.push_back(m_pw);
    end
`else
    if (m_pw != t) begin
      m_pw = t;
      exp_pw_q.push_back(t);
    end
`endif
    exp_done_q.push_back(t);
    m_out++;
  endfunction

  task automatic push(input int v, output bit acc);
    bit cl;
    cl = (v < MIN) || (v > MAX);
    @(posedge clk); #2 cmd_valid = 1'b1; cmd_pw = 16'(v);
    @(negedge clk); acc = cmd_ready;
    @(posedge clk); #2 cmd_valid = 1'b0;
    if (acc) model_cmd(v);
    @(negedge clk);
    if (acc) chk("cmd_err", {31'd0, cmd_err}, {31'd0, cl});
    else     chk("cmd_err_refused", {31'd0, cmd_err}, 32'd0);
  endtask

  task automatic pstart();
    bit d;
    int t;
    @(posedge clk); #2 period_start = 1'b1; counter_in = '0;
    @(negedge clk); d = (done === 1'b1);
    if (d) begin
      if (exp_done_q.size() == 0) chk("done_unexpected", {31'd0, done}, 32'd0);
      else begin
        t = exp_done_q.pop_front();
        chk("done_pw", {16'd0, pulse_width}, t);
        m_out--;
      end
    end
    @(posedge clk); #2 period_start = 1'b0; counter_in = 16'd300;
    @(negedge clk);
    if (d) chk("busy_after_done", {31'd0, busy}, {31'd0, m_out > 0});
  endtask

  task automatic run_idle(input string tag, input int maxp);
    for (int i = 0; i < maxp && m_out > 0; i++) pstart();
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    chk({tag, "_steps_left"}, exp_pw_q.size(), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int nacc, highs, expv;
    logic [15:0] pc;

    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rst_pw", {16'd0, pulse_width}, CEN);
    chk("rst_pwm", {31'd0, pwm_out}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_cmd_err", {31'd0, cmd_err}, 32'd0);
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    mon_off = 1'b0;

    push(1540, acc); run_idle("c1540", 20);
    push(1545, acc); run_idle("c1545", 20);
    push(3000, acc); run_idle("c3000", 150);
    chk("clamp_hi_pw", {16'd0, pulse_width}, MAX);
    push(100, acc);  run_idle("c100", 250);
    chk("clamp_lo_pw", {16'd0, pulse_width}, MIN);

    // Fill with period_start held low: one entry moves to target, DEPTH stay queued.
    nacc = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      push(1510 + 10 * i, acc);
      nacc += int'(acc);
    end
    chk("fill_accepted", nacc, DEPTH + 1);
    chk("fill_ready", {31'd0, cmd_ready}, 32'd0);
    run_idle("fill_drain", 400);

`ifdef SERVO_RAMP_EN
    push(2000, acc);
`else
    push(1700, acc);
`endif
    for (int i = 0; i < 60 && pulse_width != 16'd1700; i++) pstart();
    chk("reach_1700", {16'd0, pulse_width}, 1700);
    push(1800, acc);
    mon_off = 1'b1;
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    chk("midrst_pw", {16'd0, pulse_width}, CEN);
    chk("midrst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    exp_pw_q.delete(); exp_done_q.delete();
    m_out = 0; m_pw = CEN;
    @(posedge clk); mon_off = 1'b0;
    repeat (4) pstart();
    chk("queue_lost_busy", {31'd0, busy}, 32'd0);

    // PWM sweep at 1500 us, output lags counter_in by one clock.
    highs = 0;
    pc = '0;
    for (int c = 0; c <= 1601; c++) begin
      @(posedge clk); #2 counter_in = 16'(c); period_start = (c == 0);
      @(negedge clk);
      if (c > 0) begin
        chk("pwm_bit", {31'd0, pwm_out}, {31'd0, pc < 16'd1500});
        highs += int'(pwm_out === 1'b1);
      end
      pc = 16'(c);
    end
    chk("pwm_high_count", highs, 1500);
    period_start = 1'b0;

    push(2000, acc);
    pstart();
`ifdef SERVO_RAMP_EN
    expv = 1510;
`else
    expv = 2000;
`endif
    chk("first_period_pw", {16'd0, pulse_width}, expv);
    run_idle("c2000", 80);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
